// File: rtl/avalon_master_pkg.sv
// Shared types and constants for the Avalon-MM burst initiator.
package avalon_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } master_state_t;

  localparam logic [1:0] BE_ALL_N  = 2'b00;
  localparam logic [1:0] BE_NONE_N = 2'b11;

endpackage

// File: rtl/SyncFifo.sv
// Synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module SyncFifo #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_push,
  input  logic [FIFO_WIDTH-1:0]              i_data,
  input  logic                               i_pop,
  output logic [FIFO_WIDTH-1:0]              o_data,
  output logic                               o_empty,
  output logic                               o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/avalon_burst_master.sv
// Avalon-MM initiator moving a block of 16-bit words between a valid/ready
// stream and a word-addressed slave; reads are credit-limited by the return buffer.
module avalon_burst_master
  import avalon_master_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  input  logic [15:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] address,
  output logic              read_n,
  output logic              write_n,
  output logic [15:0]       writeData,
  output logic [1:0]        byteEnable_n,
  input  logic [15:0]       readData,
  input  logic              waitrequest,
  input  logic              readdatavalid
);
  localparam int unsigned CNT_W  = $clog2(RX_DEPTH + 1);
  localparam int unsigned CRED_W = CNT_W + 1;

  master_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]  r_remain, w_remain_nxt;
  logic [CNT_W-1:0]  r_outst, w_outst_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_wr_xfer, w_rd_issue, w_rd_accept, w_ret, w_pop;
  logic              w_fifo_empty, w_fifo_full;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CRED_W-1:0] w_credit;
  logic              w_write_n, w_read_n;

  // In-flight reads plus buffered words may never exceed the buffer depth.
  assign w_credit    = CRED_W'(r_outst) + CRED_W'(w_fifo_count);
  assign w_rd_issue  = (r_state == READ) && (r_remain != '0) && (w_credit < CRED_W'(RX_DEPTH));
  assign w_rd_accept = w_rd_issue && !waitrequest;
  assign w_wr_xfer   = (r_state == WRITE) && wr_valid && !waitrequest;
  assign w_ret       = readdatavalid && ((r_state == READ) || (r_state == DRAIN));
  assign w_pop       = !w_fifo_empty && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_outst  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_remain <= w_remain_nxt;
      r_outst  <= w_outst_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_remain_nxt = r_remain;
    w_outst_nxt  = r_outst;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    if (w_rd_accept && !w_ret)      w_outst_nxt = r_outst + CNT_W'(1);
    else if (!w_rd_accept && w_ret) w_outst_nxt = r_outst - CNT_W'(1);

    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt   = cmd_addr;
          w_remain_nxt = cmd_len;
          if (cmd_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_busy_nxt  = 1'b1;
            w_state_nxt = cmd_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (w_wr_xfer) begin
          w_addr_nxt   = r_addr + ADDR_W'(1);
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      READ: begin
        if (w_rd_accept) begin
          w_addr_nxt   = r_addr + ADDR_W'(1);
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_outst == '0) && w_fifo_empty) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  SyncFifo #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_ret && !w_fifo_full),
    .i_data (readData),
    .i_pop  (w_pop),
    .o_data (rd_data),
    .o_empty(w_fifo_empty),
    .o_full (w_fifo_full),
    .o_count(w_fifo_count)
  );

  // Avalon strobes follow the stream/credit state directly so a stalled
  // request stays asserted with the same address until accepted.
  assign w_write_n    = !((r_state == WRITE) && wr_valid);
  assign w_read_n     = !w_rd_issue;
  assign write_n      = w_write_n;
  assign read_n       = w_read_n;
  assign address      = r_addr;
  assign writeData    = (r_state == WRITE) ? wr_data : '0;
  assign byteEnable_n = (!w_write_n || !w_read_n) ? BE_ALL_N : BE_NONE_N;
  assign wr_ready     = (r_state == WRITE) && !waitrequest;
  assign rd_valid     = !w_fifo_empty;
  assign cmd_ready    = (r_state == IDLE);
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
